// File: rtl/imem_prefetch_if.sv
// Fetch-unit signal bundle: instruction-memory request channel, core
// redirect strobe, and the instruction delivery channel toward the core.
interface imem_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Prefetcher side.
    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

    // Memory/core side.
    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/imem_prefetch.sv
// Instruction prefetcher: issues sequential word fetches over a req/ack
// channel, buffers {pc, inst} pairs in a DEPTH-entry FIFO and flushes and
// re-steers on a core redirect. A redirect that arrives while a request is
// still outstanding parks the new target until the stale ack drains.
module imem_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    imem_prefetch_if.master bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pending_pc_q, pending_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic            push;
    logic            pop;
    logic            full_after;
    logic [31:0]     redir_pc;

    assign redir_pc   = bus.redirect_pc & ~32'h3;
    assign pop        = bus.inst_valid && bus.inst_ready && !bus.redirect;
    assign full_after = (count_q + CW'(1) - CW'(pop)) == CW'(DEPTH);

    // Output decode: request while FETCH/DISCARD, FIFO head gated by valid.
    always_comb begin
        bus.mem_req    = (state_q == FETCH) || (state_q == DISCARD);
        bus.mem_addr   = fetch_pc_q;
        bus.inst_valid = (count_q != '0);
        bus.inst       = bus.inst_valid ? inst_mem[rd_ptr_q] : '0;
        bus.inst_pc    = bus.inst_valid ? pc_mem[rd_ptr_q]   : '0;
    end

    // Next-state, fetch address and push decision; redirect takes priority.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        push         = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.redirect) fetch_pc_d = redir_pc;
            end
            FETCH: begin
                if (bus.redirect) begin
                    if (bus.mem_ack) begin
                        fetch_pc_d = redir_pc;
                    end else begin
                        pending_pc_d = redir_pc;
                        state_d      = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = full_after ? STALL : FETCH;
                end
            end
            STALL: begin
                if (bus.redirect) begin
                    fetch_pc_d = redir_pc;
                    state_d    = FETCH;
                end else if (count_q != CW'(DEPTH)) begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (bus.redirect) pending_pc_d = redir_pc;
                if (bus.mem_ack) begin
                    fetch_pc_d = bus.redirect ? redir_pc : pending_pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy: redirect empties the FIFO regardless of push/pop.
    always_comb begin
        count_d = count_q;
        if (bus.redirect) count_d = '0;
        else              count_d = count_q + CW'(push) - CW'(pop);
    end

    // Control state, addresses, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            count_q      <= count_d;
            if (bus.redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage; contents are only observable while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= bus.mem_rdata;
        end
    end

endmodule

// File: doc/imem_prefetch.md
# imem_prefetch

Instruction-fetch front end that sits directly upstream of Simple_core's instruction port. It generates sequential word addresses toward instruction memory over a req/ack handshake and buffers returned instructions with their PCs in a small FIFO. It delivers them to the core over a valid/ready interface and flushes and re-steers on a core redirect (taken branch/jump).

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- mem_req  output  1  fetch request to instruction memory
- mem_addr  output  32  word-aligned fetch address; valid while mem_req=1
- mem_ack  input  1  memory accepts and completes the current request this cycle
- mem_rdata  input  32  instruction word; valid when mem_ack=1
- redirect  input  1  core flush/re-steer strobe; single cycle
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0
- inst_valid  output  1  FIFO head is valid
- inst_ready  input  1  core consumes FIFO head when inst_valid=1
- inst  output  32  instruction at FIFO head
- inst_pc  output  32  address of the instruction at FIFO head

## Operation
- Registers: fetch_pc, state, FIFO (DEPTH x {pc,inst}), rd/wr pointers, count (0..DEPTH).
- States: IDLE, FETCH, STALL, DISCARD. mem_req = (state==FETCH || state==DISCARD). mem_addr = fetch_pc.
- Memory protocol: once raised, mem_req and mem_addr hold until the mem_ack cycle. There is at most one outstanding request. mem_ack while mem_req=0 is ignored.
- IDLE -> FETCH on the first clock edge with rst=1.
- FETCH, mem_ack=1, no redirect: push {fetch_pc, mem_rdata}, fetch_pc += 4 (mod 2^32). Next state is STALL if the post-update count == DEPTH, else FETCH.
- STALL -> FETCH when count < DEPTH.
- Pop: inst_valid && inst_ready. count updates as count + push - pop. Simultaneous push and pop leaves count unchanged. No push occurs while full, because no request is issued.
- Redirect has highest priority. It clears the FIFO (count=0, pointers reset) in the same edge, and any pop that cycle has no further effect. Then:
  - IDLE/STALL: fetch_pc=redirect_pc, go to FETCH.
  - FETCH with mem_ack=1: drop the returned data, fetch_pc=redirect_pc, go to FETCH.
  - FETCH with mem_ack=0: latch redirect_pc into pending_pc, go to DISCARD. The old request stays on the bus.
  - DISCARD: overwrite pending_pc; stay in DISCARD (or move to FETCH if mem_ack=1 this cycle).
- DISCARD, mem_ack=1: drop the data, fetch_pc=pending_pc, go to FETCH.
- No bypass: instruction data reaches inst/inst_pc only through the FIFO.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, count=0, state=IDLE.
- Reset assertion mid-request abandons the request immediately. Memory must also be reset.
- mem_req first rises 1 cycle after reset release.
- Latency from a mem_ack edge to inst_valid=1 is 1 cycle.
- With mem_ack tied 1 and inst_ready tied 1, sustained throughput is 1 instruction/cycle and addresses increment every cycle.
- Redirect at edge N: inst_valid=0 after edge N. mem_addr=redirect_pc after edge N, or after the stale ack edge when in DISCARD.
- Restart after full: the first pop at edge N gives STALL->FETCH at edge N+1, so mem_req=1 after N+1.

## Test plan
- Reset: hold rst=0 5 cycles -> mem_req=0, inst_valid=0, mem_addr=0. Release -> mem_req=1, mem_addr=0x0 next cycle.
- Streaming: mem_ack=1, mem_rdata=~mem_addr, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8... one per cycle, inst=~inst_pc, no gaps.
- Backpressure: inst_ready=0, DEPTH=4 -> exactly 4 acks, then mem_req=0 and mem_addr=0x10. Raise inst_ready -> heads 0x0..0xC pop in order, mem_req returns 2 cycles after the first pop.
- Redirect with pending request: ack delayed 3 cycles on addr 0x8, redirect to 0x100 -> mem_addr stays 0x8 until ack, that data never appears, next mem_addr=0x100, first inst_pc after flush=0x100.
- Redirect coincident with ack (addr 0x4, redirect_pc 0x203) -> 0x4 data dropped, next mem_addr=0x200. Back-to-back redirects in DISCARD (0x300 then 0x400) -> fetch resumes at 0x400.
- Wrap: RESET_PC=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst mid-request -> mem_req=0 immediately, restart at RESET_PC.
